// File: rtl/test_i4962.sv
// Registered 2-input XOR (odd parity) reference cell with configurable pipeline depth.
// Optional sequence monitor (00,01,10,11 -> seq_seen) enabled by defining I4962_SEQ_MON_EN.
module test_i4962 #(
  parameter int       PIPE_STAGES = 1,
  parameter logic     OUT_RST_VAL = 1'b0
) (
  input  logic CK,
  input  logic reset,
  input  logic N0,
  input  logic N1,
`ifdef I4962_SEQ_MON_EN
  output logic seq_seen,
`endif
  output logic output_single
);

  if (PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_bad_stages
    $error("test_i4962: PIPE_STAGES must be in 1..4");
  end

  logic [PIPE_STAGES-1:0] pipe;

  // NOTE: registers use non-blocking assignments so every stage samples the
  // pre-edge value of its predecessor; blocking here would collapse the pipeline.
  always_ff @(posedge CK) begin
    if (reset) begin
      pipe <= {PIPE_STAGES{OUT_RST_VAL}};
    end else begin
      pipe[0] <= N0 ^ N1;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  // Output comes straight from a flop: no combinational path from N0/N1.
  assign output_single = pipe[PIPE_STAGES-1];

`ifdef I4962_SEQ_MON_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S00  = 3'd1,
    S01  = 3'd2,
    S10  = 3'd3,
    DONE = 3'd4
  } mon_state_t;

  mon_state_t state, state_next;
  logic [1:0] pair;

  // Printed pair order: N0 is the MSB.
  assign pair = {N0, N1};

  always_ff @(posedge CK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (pair == 2'b00) ? S00 : IDLE;
      S00:     state_next = (pair == 2'b01) ? S01 :
                            (pair == 2'b00) ? S00 : IDLE;
      S01:     state_next = (pair == 2'b10) ? S10 :
                            (pair == 2'b00) ? S00 : IDLE;
      S10:     state_next = (pair == 2'b11) ? DONE :
                            (pair == 2'b00) ? S00 : IDLE;
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Moore output: rises right after the edge that samples the final 11.
  assign seq_seen = (state == DONE);
`endif

endmodule

// File: tb/tb_test_i4962.sv
// Directed self-checking bench for test_i4962: default depth, PIPE_STAGES=3 and OUT_RST_VAL=1
// instances share one stimulus stream; sequence-monitor checks run when I4962_SEQ_MON_EN is defined.
module tb_test_i4962;

  logic CK = 1'b0;
  logic reset = 1'b1;
  logic N0 = 1'b0;
  logic N1 = 1'b0;
  logic out_d1, out_d3, out_dr;
`ifdef I4962_SEQ_MON_EN
  logic seq_d1, seq_d3, seq_dr;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CK = ~CK;

  test_i4962 #(.PIPE_STAGES(1), .OUT_RST_VAL(1'b0)) d1 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1),
`ifdef I4962_SEQ_MON_EN
    .seq_seen(seq_d1),
`endif
    .output_single(out_d1)
  );

  test_i4962 #(.PIPE_STAGES(3), .OUT_RST_VAL(1'b0)) d3 (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1),
`ifdef I4962_SEQ_MON_EN
    .seq_seen(seq_d3),
`endif
    .output_single(out_d3)
  );

  test_i4962 #(.PIPE_STAGES(1), .OUT_RST_VAL(1'b1)) dr (
    .CK(CK), .reset(reset), .N0(N0), .N1(N1),
`ifdef I4962_SEQ_MON_EN
    .seq_seen(seq_dr),
`endif
    .output_single(out_dr)
  );

  // Drive reset and the pair {N0,N1}, take one rising edge, then settle 1 time unit.
  task automatic apply(input logic r, input logic [1:0] n);
    reset = r;
    N0    = n[1];
    N1    = n[0];
    @(posedge CK);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
  endtask

  initial begin
    // Reset wins over a simultaneous 11 input.
    apply(1'b1, 2'b11);
    check("rst_d1", out_d1, 1'b0);
    check("rst_d3", out_d3, 1'b0);
    check("rst_dr", out_dr, 1'b1);

    // Exhaustive sweep, one-edge latency.
    apply(1'b0, 2'b00); check("sweep_00", out_d1, 1'b0);
    apply(1'b0, 2'b01); check("sweep_01", out_d1, 1'b1);
    apply(1'b0, 2'b10); check("sweep_10", out_d1, 1'b1);
    apply(1'b0, 2'b11); check("sweep_11", out_d1, 1'b0);

    // Three-stage latency: single 01 pulse surfaces on edge k+2 only.
    apply(1'b1, 2'b00);
    apply(1'b0, 2'b01); check("lat3_e0", out_d3, 1'b0);
    apply(1'b0, 2'b00); check("lat3_e1", out_d3, 1'b0);
    apply(1'b0, 2'b00); check("lat3_e2", out_d3, 1'b1);
    apply(1'b0, 2'b00); check("lat3_e3", out_d3, 1'b0);
    apply(1'b0, 2'b00); check("lat3_e4", out_d3, 1'b0);

    // Mid-run reset flushes the pipeline.
    apply(1'b0, 2'b01); check("mid_pre0", out_d1, 1'b1);
    apply(1'b0, 2'b01); check("mid_pre1", out_d1, 1'b1);
    apply(1'b1, 2'b01);
    check("mid_rst_d1", out_d1, 1'b0);
    check("mid_rst_d3", out_d3, 1'b0);
    apply(1'b0, 2'b01);
    check("mid_post_d1", out_d1, 1'b1);
    check("mid_post_d3", out_d3, 1'b0);
    apply(1'b0, 2'b01); check("mid_post_d3_e1", out_d3, 1'b0);
    apply(1'b0, 2'b01); check("mid_post_d3_e2", out_d3, 1'b1);

    // Non-zero reset value.
    apply(1'b1, 2'b00); check("rstval_hold0", out_dr, 1'b1);
    apply(1'b1, 2'b11); check("rstval_hold1", out_dr, 1'b1);
    apply(1'b0, 2'b00); check("rstval_rel", out_dr, 1'b0);
    apply(1'b0, 2'b10); check("rstval_run", out_dr, 1'b1);

`ifdef I4962_SEQ_MON_EN
    apply(1'b1, 2'b00); check("seq_rst", seq_d1, 1'b0);
    apply(1'b0, 2'b00); check("seq_a00", seq_d1, 1'b0);
    apply(1'b0, 2'b01); check("seq_a01", seq_d1, 1'b0);
    apply(1'b0, 2'b10); check("seq_a10", seq_d1, 1'b0);
    apply(1'b0, 2'b11); check("seq_a11", seq_d1, 1'b1);
    apply(1'b0, 2'b01); check("seq_sticky0", seq_d1, 1'b1);
    apply(1'b0, 2'b00); check("seq_sticky1", seq_d1, 1'b1);
    apply(1'b1, 2'b00); check("seq_rst2", seq_d1, 1'b0);
    apply(1'b0, 2'b00); check("seq_b00", seq_d1, 1'b0);
    apply(1'b0, 2'b01); check("seq_b01", seq_d1, 1'b0);
    apply(1'b0, 2'b11); check("seq_b11", seq_d1, 1'b0);
    apply(1'b0, 2'b10); check("seq_b10", seq_d1, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
